// File: rtl/demux1x2_tdm_rx.sv
// 1-to-2 time-division demultiplexer: locks onto sync-marked channel-0 slots and
// delivers each completed (ch0, ch1) pair on registered outputs with a valid strobe.
module demux1x2_tdm_rx #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             out_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP1 = 2'd1,
        EXP0 = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            hold0     <= '0;
            y0        <= '0;
            y1        <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (in_sync) begin
                            hold0 <= in_data;
                            state <= EXP1;
                        end
                    end
                    EXP1: begin
                        if (in_sync) begin
                            // missing channel-1 slot: restart the pair on this sample
                            sync_err <= 1'b1;
                            hold0    <= in_data;
                        end else begin
                            y0        <= hold0;
                            y1        <= in_data;
                            out_valid <= 1'b1;
                            pair_cnt  <= pair_cnt + CNT_W'(1);
                            state     <= EXP0;
                        end
                    end
                    EXP0: begin
                        if (in_sync) begin
                            hold0 <= in_data;
                            state <= EXP1;
                        end else begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign locked = (state != HUNT);

endmodule

// File: doc/demux1x2_tdm_rx.md
# demux1x2_tdm_rx

Receive-side counterpart of the 2:1 multiplexer: a clocked 1-to-2 time-division demultiplexer. A single stream carries channel 0 and channel 1 samples in alternating slots, with a sync flag marking each channel-0 slot. The block locks onto that framing and presents each completed pair on two registered outputs with a one-cycle valid strobe. It also flags framing errors and counts delivered pairs.

## Interface
- `WIDTH`, default 1: sample width in bits.
- `CNT_W`, default 8: width of the delivered-pair counter.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: `in_data` and `in_sync` are meaningful this cycle.
- `in_sync` input, 1 bit: this sample is a channel-0 slot (frame start). Ignored when `in_valid`=0.
- `in_data` input, WIDTH bits: multiplexed sample.
- `y0` output, WIDTH bits: channel-0 sample of the last completed pair.
- `y1` output, WIDTH bits: channel-1 sample of the last completed pair.
- `out_valid` output, 1 bit: one-cycle pulse when `y0`/`y1` were just updated.
- `sync_err` output, 1 bit: one-cycle pulse on a framing violation.
- `locked` output, 1 bit: high whenever the FSM is not in HUNT.
- `pair_cnt` output, CNT_W bits: number of delivered pairs, modulo 2^CNT_W.

## Operation
Internal state: FSM {HUNT, EXP1, EXP0}, plus a WIDTH-bit `hold0` register.

- **Accepted sample:** a cycle with `in_valid`=1. When `in_valid`=0 the state, `hold0`, `y0`, `y1` and `pair_cnt` all hold, and `out_valid` and `sync_err` are 0. Gaps of any length between samples are legal.
- **HUNT**
  - Accepted sample with `in_sync`=1: `hold0`<=`in_data`, go to EXP1.
  - Accepted sample with `in_sync`=0: discarded, no error, stay in HUNT.
- **EXP1** (expecting a channel-1 sample)
  - `in_sync`=0: `y0`<=`hold0`, `y1`<=`in_data`, `out_valid`<=1, `pair_cnt`<=`pair_cnt`+1, go to EXP0.
  - `in_sync`=1 (missing channel-1 slot): `sync_err`<=1, the old `hold0` is dropped, `hold0`<=`in_data`, stay in EXP1. Nothing is delivered.
- **EXP0** (expecting the next frame start)
  - `in_sync`=1: `hold0`<=`in_data`, go to EXP1.
  - `in_sync`=0 (lost framing): `sync_err`<=1, sample discarded, go to HUNT.
- `y0` and `y1` change only on delivery and never show a partial pair.
- `pair_cnt` wraps from 2^CNT_W−1 to 0 without flagging.
- `out_valid` and `sync_err` are never high in the same cycle.

## Timing
- **Reset values:** state=HUNT, `hold0`=0, `y0`=0, `y1`=0, `out_valid`=0, `sync_err`=0, `locked`=0, `pair_cnt`=0.
- Reset takes effect immediately on `rst_n` falling, independent of `clk`.
- **Reset mid-frame:** a reset in EXP1 discards `hold0`; no pair is delivered after release.
- After `rst_n` rises, the first edge that samples `in_sync`=`in_valid`=1 moves the FSM to EXP1.
- **Latency:** `y0`, `y1`, `out_valid` and `pair_cnt` update on the same edge that accepts the channel-1 sample. They are visible one cycle after that sample is presented.
- `out_valid` and `sync_err` are registered and high for exactly one cycle per event.
- `locked` is combinational from the state register and has no glitch-free requirement beyond that.
- **Throughput:** one accepted sample per clock. Back-to-back frames give `out_valid` every second cycle.

## Test plan
1. **Reset state:** assert `rst_n`=0 mid-cycle.
   - Immediately, all outputs read 0 and `locked`=0.
   - Hold reset for 3 cycles; outputs stay 0.
2. **Basic pair, WIDTH=4:** present (sync=1, data=4'hA), then (sync=0, data=4'h5) on consecutive cycles.
   - Next cycle: `y0`=A, `y1`=5, `out_valid`=1 for one cycle, `pair_cnt`=1, `locked`=1.
3. **Gaps:** present A/sync, 3 idle cycles, then 5.
   - Same result as scenario 2.
   - No `out_valid` pulse during the gap.
4. **Framing errors:**
   - Present 1/sync, 2/sync, 3: one `sync_err` pulse after 2, then a pair `y0`=2, `y1`=3.
   - Then present 7 with no sync in EXP0: `sync_err` pulses, `locked` drops to 0, and `y0`/`y1` stay 2/3.
5. **Hunt discard and counter wrap:**
   - From reset, present 3 non-sync samples: no outputs change and no error.
   - Then, with CNT_W=2, stream 5 back-to-back frames: `pair_cnt` reads 1, 2, 3, 0, 1.
   - `out_valid` pulses every second cycle.
6. **Reset mid-frame:** present 9/sync, then pulse `rst_n` low for 1 cycle, then present 4 (no sync).
   - No `out_valid`, `y0`=`y1`=0, and the FSM stays in HUNT.
